tdc_uart_packetizer: RTL and testbench
======================================

// Module: tdc_uart_packetizer
// PURPOSE
//  Downstream of the TDC core, upstream of the UART transmitter driving tx.
//  Buffers 40-bit TDC measurement words in a small FIFO.
//  Serialises each word into a framed byte stream:
//    header, DATA_W/8 data bytes MSB-first, XOR checksum.
//  Presents bytes to the UART TX over a valid/ready handshake; counts words dropped on overflow.
// PARAMETERS
//  DATA_W      40     TDC word width; must be a multiple of 8 (NBYTES = DATA_W/8)
//  FIFO_DEPTH  4      word buffer depth; power of two, >= 2
//  HEADER      8'hA5  frame start byte
// PORTS
//  clk         in   1       system clock, all logic on rising edge
//  reset       in   1       synchronous, active-high
//  tdc_data    in   DATA_W  TDC measurement word
//  tdc_valid   in   1       1-cycle strobe: tdc_data valid this cycle
//  tx_byte     out  8       byte to UART TX
//  tx_valid    out  1       tx_byte valid
//  tx_ready    in   1       UART TX accepts tx_byte this cycle
//  fifo_full   out  1       FIFO holds FIFO_DEPTH words
//  busy        out  1       frame in progress or FIFO non-empty
//  drop_count  out  16      words lost to overflow, saturates at 16'hFFFF
// BEHAVIOUR
//  Reset values
//   - tx_valid=0, tx_byte=0, fifo_full=0, busy=0, drop_count=0.
//   - FIFO pointers cleared; state=IDLE.
//   - Reset mid-frame aborts the frame; no partial frame resumes.
//  FIFO write
//   - tdc_valid && !full: write at edge.
//   - tdc_valid && full && no pop same cycle: word dropped, drop_count++ (saturating).
//   - Same-cycle pop and write while full: write accepted, no drop.
//  Byte handshake
//   - Byte transfers on any edge with tx_valid && tx_ready.
//   - tx_valid, once high, stays high and tx_byte stays stable until the transfer.
//   - tx_ready is ignored while tx_valid=0.
//  FSM
//   - IDLE: if FIFO non-empty, pop head into shift register, clear csum, load tx_byte=HEADER, tx_valid=1 -> HDR.
//   - HDR: on transfer, tx_byte=shift[DATA_W-1 -: 8], idx=0 -> DATA.
//   - DATA: on transfer, csum ^= tx_byte, shift <<= 8, idx++.
//     - idx==NBYTES-1 at the transfer: tx_byte=csum^tx_byte -> CSUM.
//     - else tx_byte = next data byte.
//   - CSUM: on transfer, tx_valid=0 -> IDLE. The next frame may start the following cycle.
//  Timing
//   - Latency: tdc_valid sampled at edge N into an empty FIFO with IDLE -> tx_valid=1 with HEADER after edge N+1.
//   - Frame length: NBYTES+2 bytes (7 at default).
//   - Back-to-back frames: with tx_ready held high, one IDLE cycle between frames.
//  Outputs
//   - fifo_full, busy: registered, updated at the same edge as the pointers.
// TESTING
//  - Word 40'h0123456789, tx_ready=1 -> bytes A5,01,23,45,67,89,89 on consecutive transfers.
//  - Same word, tx_ready low for 3 cycles while byte 01 is presented -> tx_byte holds 01 and tx_valid stays high; stream otherwise identical.
//  - tx_ready=0, 6 tdc_valid strobes on consecutive cycles -> first word in the shift register, 4 words in FIFO, fifo_full=1, drop_count=1.
//  - FIFO full, IDLE pop coincident with tdc_valid -> no drop, fifo_full stays 1, drop_count unchanged.
//  - Reset asserted 1 cycle during data byte 3 -> next cycle tx_valid=0, busy=0, drop_count=0; a new word then yields a full 7-byte frame.
//  - 2 words 40'hFFFFFFFFFF, 40'h0 back-to-back, tx_ready=1 -> frames A5,FF x5,FF then A5,00 x5,00, with one idle cycle between.

Source files
------------

// File: rtl/tdc_uart_packetizer.sv
// Frames buffered TDC words as HEADER, data bytes MSB-first, XOR checksum for a UART TX.
// Latency: header is presented one edge after the FIFO write. tx_ready low holds the byte. A full FIFO drops and counts words.
module tdc_uart_packetizer #(
  parameter int         DATA_W     = 40,
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] HEADER     = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] tdc_data,
  input  logic              tdc_valid,
  output logic [7:0]        tx_byte,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              fifo_full,
  output logic              busy,
  output logic [15:0]       drop_count
);

  localparam int NBYTES = DATA_W / 8;
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [AW:0]      DEPTH_C  = FIFO_DEPTH[AW:0];
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBYTES - 1);

  typedef enum logic [1:0] {IDLE, HDR, DATA, CSUM} state_t;

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_d;
  logic              full_q, full_d, busy_q, busy_d;
  logic [15:0]       drop_q, drop_d;
  state_t            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [7:0]        csum_q, csum_d, byte_q, byte_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              vld_q, vld_d;
  logic              empty, pop, push, xfer;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign xfer  = vld_q && tx_ready;
  assign pop   = (state_q == IDLE) && !empty;
  // A pop in the same cycle frees the slot, so a write while full is still accepted.
  assign push  = tdc_valid && (!full_q || pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
    count_d  = wr_ptr_d - rd_ptr_d;
    full_d   = (count_d == DEPTH_C);
    drop_d   = drop_q;
    if (tdc_valid && full_q && !pop && (drop_q != 16'hFFFF)) begin
      drop_d = drop_q + 16'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    csum_d  = csum_q;
    byte_d  = byte_q;
    idx_d   = idx_q;
    vld_d   = vld_q;
    case (state_q)
      IDLE: begin
        if (pop) begin
          shift_d = mem_q[rd_ptr_q[AW-1:0]];
          csum_d  = 8'h00;
          byte_d  = HEADER;
          vld_d   = 1'b1;
          state_d = HDR;
        end
      end
      HDR: begin
        if (xfer) begin
          byte_d  = shift_q[DATA_W-1 -: 8];
          idx_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (xfer) begin
          csum_d  = csum_q ^ byte_q;
          shift_d = shift_q << 8;
          idx_d   = idx_q + IDX_W'(1);
          if (idx_q == IDX_LAST) begin
            byte_d  = csum_q ^ byte_q;
            state_d = CSUM;
          end else begin
            byte_d = shift_d[DATA_W-1 -: 8];
          end
        end
      end
      CSUM: begin
        if (xfer) begin
          vld_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE) || (count_d != '0);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= tdc_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      full_q   <= 1'b0;
      busy_q   <= 1'b0;
      drop_q   <= 16'h0000;
      state_q  <= IDLE;
      shift_q  <= '0;
      csum_q   <= 8'h00;
      byte_q   <= 8'h00;
      idx_q    <= '0;
      vld_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      full_q   <= full_d;
      busy_q   <= busy_d;
      drop_q   <= drop_d;
      state_q  <= state_d;
      shift_q  <= shift_d;
      csum_q   <= csum_d;
      byte_q   <= byte_d;
      idx_q    <= idx_d;
      vld_q    <= vld_d;
    end
  end

  assign tx_byte    = byte_q;
  assign tx_valid   = vld_q;
  assign fifo_full  = full_q;
  assign busy       = busy_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_tdc_uart_packetizer.sv
// Bench for tdc_uart_packetizer: queue-based reference model checked every cycle, plus literal frame checks.
module tb_tdc_uart_packetizer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [39:0] tdc_data;
  logic        tdc_valid;
  logic [7:0]  tx_byte;
  logic        tx_valid;
  logic        tx_ready;
  logic        fifo_full;
  logic        busy;
  logic [15:0] drop_count;

  always #5 clk = ~clk;

  tdc_uart_packetizer dut (
    .clk        (clk),
    .reset      (reset),
    .tdc_data   (tdc_data),
    .tdc_valid  (tdc_valid),
    .tx_byte    (tx_byte),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .fifo_full  (fifo_full),
    .busy       (busy),
    .drop_count (drop_count)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [39:0] m_fifo  [$];
  logic [7:0]  m_frame [$];
  logic [7:0]  fr      [$];
  logic [7:0]  exp_q   [$];
  logic [7:0]  got     [$];
  int          got_cyc [$];
  int          m_drop = 0;
  logic        p_vld  = 1'b0;
  logic [7:0]  p_byte = 8'h00;
  bit          m_xfer, m_pop, m_full;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Frame of a word: header, five bytes MSB-first, XOR of those five bytes.
  function automatic void make_frame(input logic [39:0] w);
    logic [7:0] b, cs;
    fr.delete();
    fr.push_back(8'hA5);
    cs = 8'h00;
    for (int i = 0; i < 5; i++) begin
      b  = 8'((w >> (8 * (4 - i))) & 40'hFF);
      cs = cs ^ b;
      fr.push_back(b);
    end
    fr.push_back(cs);
  endfunction

  task automatic cmp_q(input string nm, input logic [7:0] a [$]);
    chk({nm, "_len"}, longint'(a.size()), longint'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < a.size()) chk(nm, longint'(a[i]), longint'(exp_q[i]));
    end
  endtask

  task automatic wait_idle(input int maxc, input string nm);
    bit ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (!busy && !tx_valid) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s_timeout actual=busy required=idle within %0d cycles", nm, maxc);
    end
  endtask

  // Reference model advances on each edge; DUT outputs are compared 1 time unit later.
  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      m_fifo.delete();
      m_frame.delete();
      m_drop = 0;
    end else begin
      if (p_vld && tx_ready) begin
        got.push_back(p_byte);
        got_cyc.push_back(cyc);
      end
      m_xfer = (m_frame.size() > 0) && tx_ready;
      m_pop  = (m_frame.size() == 0) && (m_fifo.size() > 0);
      m_full = (m_fifo.size() == DEPTH);
      if (m_xfer) void'(m_frame.pop_front());
      if (m_pop) begin
        make_frame(m_fifo.pop_front());
        m_frame = fr;
      end
      if (tdc_valid) begin
        if (!m_full || m_pop) m_fifo.push_back(tdc_data);
        else if (m_drop < 65535) m_drop++;
      end
    end
    #1;
    chk("tx_valid", longint'(tx_valid), longint'(m_frame.size() > 0));
    if (m_frame.size() > 0) chk("tx_byte", longint'(tx_byte), longint'(m_frame[0]));
    chk("fifo_full", longint'(fifo_full), longint'(m_fifo.size() == DEPTH));
    chk("busy", longint'(busy), longint'((m_frame.size() > 0) || (m_fifo.size() > 0)));
    chk("drop_count", longint'(drop_count), longint'(m_drop));
    p_vld  = tx_valid;
    p_byte = tx_byte;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; tdc_valid = 1'b0; tdc_data = '0; tx_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_tx_valid", longint'(tx_valid), 0);
    chk("rst_tx_byte", longint'(tx_byte), 0);
    chk("rst_fifo_full", longint'(fifo_full), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_drop", longint'(drop_count), 0);

    exp_q = '{8'hA5, 8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'h89};
    make_frame(40'h0123456789);
    cmp_q("model_frame", fr);
    reset = 1'b0;

    // Plain frame with tx_ready high, plus first-header latency.
    got.delete();
    tx_ready = 1'b1; tdc_data = 40'h0123456789; tdc_valid = 1'b1;
    @(negedge clk); tdc_valid = 1'b0;
    chk("lat_write_edge_vld", longint'(tx_valid), 0);
    @(negedge clk);
    chk("lat_hdr_vld", longint'(tx_valid), 1);
    chk("lat_hdr_byte", longint'(tx_byte), 'hA5);
    wait_idle(30, "frame1");
    cmp_q("frame1", got);

    // Stall while byte 01 is presented.
    got.delete();
    tx_ready = 1'b0; tdc_valid = 1'b1;
    @(negedge clk); tdc_valid = 1'b0;
    @(negedge clk); tx_ready = 1'b1;
    @(negedge clk); tx_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("hold_vld", longint'(tx_valid), 1);
      chk("hold_byte", longint'(tx_byte), 'h01);
    end
    tx_ready = 1'b1;
    wait_idle(30, "stall");
    cmp_q("stall_frame", got);

    // Overflow: six strobes with the sink stalled.
    tx_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tdc_valid = 1'b1; tdc_data = {8'($urandom), $urandom};
      @(negedge clk);
    end
    tdc_valid = 1'b0;
    chk("ovf_full", longint'(fifo_full), 1);
    chk("ovf_drop", longint'(drop_count), 1);
    chk("ovf_hdr", longint'(tx_byte), 'hA5);

    // Drain one frame, then strobe exactly on the IDLE pop while full.
    tx_ready = 1'b1;
    repeat (7) @(negedge clk);
    chk("idle_gap_vld", longint'(tx_valid), 0);
    tdc_valid = 1'b1; tdc_data = {8'($urandom), $urandom};
    @(negedge clk); tdc_valid = 1'b0;
    chk("popwr_full", longint'(fifo_full), 1);
    chk("popwr_drop", longint'(drop_count), 1);
    chk("popwr_vld", longint'(tx_valid), 1);
    wait_idle(100, "drain");

    // Reset during data byte 3.
    tdc_data = 40'h0123456789; tdc_valid = 1'b1;
    @(negedge clk); tdc_valid = 1'b0;
    begin
      bit found = 1'b0;
      for (int i = 0; i < 20; i++) begin
        if (tx_valid && tx_byte == 8'h45) begin
          found = 1'b1;
          break;
        end
        @(negedge clk);
      end
      chk("find_byte3", longint'(found), 1);
    end
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    chk("mid_rst_vld", longint'(tx_valid), 0);
    chk("mid_rst_busy", longint'(busy), 0);
    chk("mid_rst_drop", longint'(drop_count), 0);
    got.delete();
    tdc_data = 40'hDEADBEEF01; tdc_valid = 1'b1;
    @(negedge clk); tdc_valid = 1'b0;
    wait_idle(30, "post_rst");
    exp_q = '{8'hA5, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23};
    cmp_q("post_rst_frame", got);

    // Back-to-back all-ones and all-zeros frames.
    got.delete();
    tdc_data = 40'hFFFFFFFFFF; tdc_valid = 1'b1;
    @(negedge clk); tdc_data = 40'h0;
    @(negedge clk); tdc_valid = 1'b0;
    wait_idle(60, "b2b");
    exp_q = '{8'hA5, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
              8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    cmp_q("b2b_frames", got);
    if (got_cyc.size() == 14) chk("b2b_gap", longint'(got_cyc[7] - got_cyc[6]), 2);

    // Random traffic, backpressure and occasional resets.
    repeat (600) begin
      tdc_valid = ($urandom % 3) == 0;
      tdc_data  = {8'($urandom), $urandom};
      tx_ready  = ($urandom % 5) != 0;
      reset     = ($urandom % 200) == 0;
      @(negedge clk);
    end
    reset = 1'b0; tdc_valid = 1'b0; tx_ready = 1'b1;
    wait_idle(200, "final_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
